// File: rtl/demux_1_8_sched_if.sv
// Handshake and channel bus between a bit source, the round-robin dispatcher
// and the 1:8 demux it sequences.
interface demux_1_8_sched_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic [7:0]       ch_en;
  logic [7:0]       ch_ack;
  logic [2:0]       sel;
  logic             dmx_i;
  logic [7:0]       out_valid;
  logic             busy;
  logic             drop_err;
  logic [CNT_W-1:0] dlv_cnt;

  modport master (
    output in_valid, in_data, ch_en, ch_ack,
    input  in_ready, sel, dmx_i, out_valid, busy, drop_err, dlv_cnt
  );

  modport slave (
    input  in_valid, in_data, ch_en, ch_ack,
    output in_ready, sel, dmx_i, out_valid, busy, drop_err, dlv_cnt
  );
endinterface

// File: rtl/demux_1_8_sched.sv
// Round-robin dispatcher for a 1:8 demux: accepts one bit per handshake, sets the
// selects, strobes the chosen channel until it acks or times out, then releases.
module demux_1_8_sched #(
  parameter int ACK_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_1_8_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, RELEASE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_nxt;
  logic [2:0]       ptr_q, ptr_nxt;
  logic [2:0]       ch_q, ch_nxt;
  logic             data_q, data_nxt;
  logic [TO_W-1:0]  timer_q, timer_nxt;
  logic [2:0]       sel_q, sel_nxt;
  logic             dmx_q, dmx_nxt;
  logic [7:0]       ov_q, ov_nxt;
  logic             in_ready_q, in_ready_nxt;
  logic             busy_q, busy_nxt;
  logic             drop_q, drop_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic       accept;
  logic       ack_hit;
  logic       timeout_hit;
  logic [2:0] pick_ch;

  // First enabled channel at or after start, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] en, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_ch     = rr_pick(bus.ch_en, ptr_q);
  assign accept      = (state_q == IDLE) && bus.in_valid && in_ready_q && (bus.ch_en != 8'h00);
  assign ack_hit     = bus.ch_ack[ch_q];
  assign timeout_hit = (timer_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ch_q       <= '0;
      data_q     <= 1'b0;
      timer_q    <= '0;
      sel_q      <= '0;
      dmx_q      <= 1'b0;
      ov_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      ptr_q      <= ptr_nxt;
      ch_q       <= ch_nxt;
      data_q     <= data_nxt;
      timer_q    <= timer_nxt;
      sel_q      <= sel_nxt;
      dmx_q      <= dmx_nxt;
      ov_q       <= ov_nxt;
      in_ready_q <= in_ready_nxt;
      busy_q     <= busy_nxt;
      drop_q     <= drop_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = DRIVE;
      DRIVE:   if (ack_hit || timeout_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so each value here is what the next state shows.
  always_comb begin
    sel_nxt      = sel_q;
    dmx_nxt      = 1'b0;
    ov_nxt       = '0;
    drop_nxt     = 1'b0;
    cnt_nxt      = cnt_q;
    ptr_nxt      = ptr_q;
    ch_nxt       = ch_q;
    data_nxt     = data_q;
    timer_nxt    = timer_q;
    in_ready_nxt = (state_nxt == IDLE) && (bus.ch_en != 8'h00);
    busy_nxt     = (state_nxt != IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_nxt   = pick_ch;
          data_nxt = bus.in_data;
          sel_nxt  = pick_ch;
        end
      end
      SETUP: begin
        timer_nxt = '0;
        dmx_nxt   = data_q;
        ov_nxt    = 8'h01 << ch_q;
      end
      DRIVE: begin
        if (ack_hit) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end else if (timeout_hit) begin
          drop_nxt = 1'b1;
        end else begin
          timer_nxt = timer_q + TO_W'(1);
          dmx_nxt   = data_q;
          ov_nxt    = 8'h01 << ch_q;
        end
      end
      RELEASE: ptr_nxt = ch_q + 3'd1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sel       = sel_q;
  assign bus.dmx_i     = dmx_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = busy_q;
  assign bus.drop_err  = drop_q;
  assign bus.dlv_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_1_8_sched.sv
// Bench for demux_1_8_sched: per-word behavioural model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_demux_1_8_sched;
  localparam int ACK_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1_8_sched_if #(.CNT_W(8)) bus();

  demux_1_8_sched #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int ack_mode = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one word at a time, tracked by its age in cycles since acceptance.
  logic       m_word;
  int         m_t;
  int         m_end;
  logic [2:0] m_ch, m_ptr, m_sel;
  logic       m_bit, m_rdy, m_drop;
  logic [7:0] m_cnt;

  function automatic logic [2:0] next_ch(input logic [7:0] en, input logic [2:0] p);
    for (int k = 0; k < 8; k++)
      if (en[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_word <= 1'b0; m_t <= 0; m_end <= 0; m_ch <= '0; m_ptr <= '0; m_sel <= '0;
      m_bit <= 1'b0; m_rdy <= 1'b0; m_drop <= 1'b0; m_cnt <= '0;
    end else begin
      m_drop <= 1'b0;
      if (m_word) begin
        if (m_end != 0) begin
          m_word <= 1'b0;
          m_ptr  <= m_ch + 3'd1;
          m_rdy  <= (bus.ch_en != 8'h00);
        end else begin
          if (m_t >= 2) begin
            if (bus.ch_ack[m_ch]) begin
              m_cnt <= m_cnt + 8'd1;
              m_end <= m_t;
            end else if (m_t - 1 == ACK_TIMEOUT) begin
              m_end  <= m_t;
              m_drop <= 1'b1;
            end
          end
          m_t <= m_t + 1;
        end
      end else if (bus.in_valid && m_rdy && bus.ch_en != 8'h00) begin
        m_word <= 1'b1;
        m_t    <= 1;
        m_end  <= 0;
        m_ch   <= next_ch(bus.ch_en, m_ptr);
        m_sel  <= next_ch(bus.ch_en, m_ptr);
        m_bit  <= bus.in_data;
        m_rdy  <= 1'b0;
      end else begin
        m_rdy <= (bus.ch_en != 8'h00);
      end
    end
  end

  logic [7:0] log_ov[$];
  logic [2:0] log_sel[$];
  logic [7:0] prev_ov;

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      chk("in_ready",  bus.in_ready,  m_rdy);
      chk("busy",      bus.busy,      m_word);
      chk("sel",       bus.sel,       m_sel);
      chk("out_valid", bus.out_valid, (m_word && m_t >= 2 && m_end == 0) ? (8'h01 << m_ch) : 8'h00);
      chk("dmx_i",     bus.dmx_i,     (m_word && m_t >= 2 && m_end == 0) ? m_bit : 1'b0);
      chk("drop_err",  bus.drop_err,  m_drop);
      chk("dlv_cnt",   bus.dlv_cnt,   m_cnt);
      if (bus.out_valid != 8'h00 && prev_ov == 8'h00) begin
        log_ov.push_back(bus.out_valid);
        log_sel.push_back(bus.sel);
      end
      prev_ov <= bus.out_valid;
    end else begin
      prev_ov <= 8'h00;
    end
  end

  always @(negedge clk) begin
    case (ack_mode)
      1:       bus.ch_ack = bus.out_valid;
      2:       bus.ch_ack = 8'($urandom & $urandom);
      3:       bus.ch_ack = 8'($urandom & $urandom & $urandom & $urandom);
      default: bus.ch_ack = 8'h00;
    endcase
  end

  task automatic send(input logic d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!(bus.in_ready && bus.ch_en != 8'h00) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || m_word) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_ov.delete();
    log_sel.delete();
  endtask

  initial begin
    int n_on, n_drop, n_bad;
    logic [2:0] exp_sel3 [3];
    logic [7:0] exp_ov3  [3];
    exp_sel3 = '{3'd2, 3'd7, 3'd2};
    exp_ov3  = '{8'h04, 8'h80, 8'h04};

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.ch_en = 8'hFF; bus.ch_ack = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("t1_ready_after_reset", bus.in_ready, 1'b1);

    // Full mask, immediate acks: strict rotation through all eight channels.
    ack_mode = 1;
    clear_log();
    for (int i = 0; i < 9; i++) send(1'($urandom));
    wait_idle();
    chk("t2_dlv_cnt", bus.dlv_cnt, 32'd9);
    chk("t2_words", log_ov.size(), 32'd9);
    for (int i = 0; i < 9 && i < log_ov.size(); i++) begin
      chk("t2_ov",  log_ov[i],  32'h1 << (i % 8));
      chk("t2_sel", log_sel[i], 32'(i % 8));
    end

    // Sparse mask from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ch_en = 8'b1000_0100;
    clear_log();
    for (int i = 0; i < 3; i++) send(1'b1);
    wait_idle();
    chk("t3_words", log_ov.size(), 32'd3);
    for (int i = 0; i < 3 && i < log_ov.size(); i++) begin
      chk("t3_ov",  log_ov[i],  exp_ov3[i]);
      chk("t3_sel", log_sel[i], exp_sel3[i]);
    end

    // No channel enabled: nothing may be accepted.
    bus.ch_en = 8'h00;
    bus.in_valid = 1'b1;
    clear_log();
    n_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_ready || bus.busy || bus.out_valid != 8'h00) n_bad++;
    end
    chk("t4_idle_cycles", n_bad, 32'd0);
    bus.ch_en = 8'h10;
    send(1'b1);
    wait_idle();
    chk("t4_words", log_ov.size(), 32'd1);
    if (log_ov.size() > 0) begin
      chk("t4_ov",  log_ov[0],  32'h10);
      chk("t4_sel", log_sel[0], 32'd4);
    end
    chk("t4_dlv_cnt", bus.dlv_cnt, 32'd4);

    // Never acked: strobe lasts the full timeout, then one drop pulse.
    bus.ch_en = 8'h01;
    ack_mode = 0;
    send(1'b1);
    n_on = 0; n_drop = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid == 8'h01) n_on++;
      if (bus.drop_err) n_drop++;
    end
    chk("t5_strobe_cycles", n_on, 32'd15);
    chk("t5_drop_pulses", n_drop, 32'd1);
    chk("t5_dlv_cnt", bus.dlv_cnt, 32'd4);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_ready", bus.in_ready, 1'b1);

    // Reset while strobing channel 3.
    bus.ch_en = 8'h08;
    send(1'b1);
    repeat (3) @(negedge clk);
    chk("t6_ov_before", bus.out_valid, 32'h08);
    chk("t6_sel_before", bus.sel, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ov", bus.out_valid, 32'h00);
    chk("t6_rst_dmx", bus.dmx_i, 1'b0);
    chk("t6_rst_sel", bus.sel, 32'd0);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_ready", bus.in_ready, 1'b0);
    chk("t6_rst_drop", bus.drop_err, 1'b0);
    chk("t6_rst_cnt", bus.dlv_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.ch_en = 8'hFF;
    ack_mode = 1;
    @(negedge clk);
    chk("t6_ready_after_reset", bus.in_ready, 1'b1);
    clear_log();
    send(1'b1);
    wait_idle();
    chk("t6_words", log_ov.size(), 32'd1);
    if (log_ov.size() > 0) begin
      chk("t6_ov",  log_ov[0],  32'h01);
      chk("t6_sel", log_sel[0], 32'd0);
    end

    // Randomized traffic, masks and acks; the per-cycle model does the checking.
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 25 == 0) bus.ch_en = 8'($urandom);
      if (cyc % 100 == 50) bus.ch_en = 8'h00;
      ack_mode = ((cyc / 60) % 2 == 1) ? 3 : 2;
      bus.in_valid = 1'($urandom);
      bus.in_data  = 1'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.ch_en = 8'hFF;
    ack_mode = 1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
